// File: rtl/frame_buffer_dbuf.sv
// -----------------------------------------------------------------------------
// frame_buffer_dbuf
//
// Double-buffered frame store between a rasterizer and a DVI output FIFO.
// The rasterizer writes (x, y, color) into the back bank while the front bank
// is scanned out in raster order. Banks swap only when the scan wraps from the
// last address back to 0, so a frame is never torn. After a swap the new back
// bank can optionally be filled with CLEAR_COLOR before drawing resumes.
//
// Ports
//   clk                   system clock
//   rst                   asynchronous, active-high reset
//   rast_pixel_rdy        rasterizer pixel valid
//   rast_width            pixel x coordinate
//   rast_height           pixel y coordinate
//   rast_color_input      pixel color
//   rast_done             rasterizer finished the current frame (level)
//   next_frame_switch     downstream stage requests a frame swap (level)
//   read_rast_pixel_rdy   pixel accepted (1-cycle pulse, one cycle after valid)
//   rast_busy             back bank not writable (waiting for swap or clearing)
//   oob_err               sticky: out-of-range pixel seen since reset
//   dvi_fifo_full         DVI FIFO full; sampled when a read is issued
//   dvi_color_out         scanout pixel
//   dvi_fifo_write_enable dvi_color_out valid, push into FIFO
//   frame_start           qualifies pixel (0,0) of the scanout frame
//   front_sel             bank currently being scanned out
// -----------------------------------------------------------------------------
module frame_buffer_dbuf #(
  parameter int                 H_RES         = 640,
  parameter int                 V_RES         = 480,
  parameter int                 X_W           = 10,
  parameter int                 Y_W           = 9,
  parameter int                 COLOR_W       = 3,
  parameter bit                 CLEAR_ON_SWAP = 1'b1,
  parameter logic [COLOR_W-1:0] CLEAR_COLOR   = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rast_pixel_rdy,
  input  logic [X_W-1:0]     rast_width,
  input  logic [Y_W-1:0]     rast_height,
  input  logic [COLOR_W-1:0] rast_color_input,
  input  logic               rast_done,
  input  logic               next_frame_switch,
  output logic               read_rast_pixel_rdy,
  output logic               rast_busy,
  output logic               oob_err,
  input  logic               dvi_fifo_full,
  output logic [COLOR_W-1:0] dvi_color_out,
  output logic               dvi_fifo_write_enable,
  output logic               frame_start,
  output logic               front_sel
);

  localparam int                DEPTH     = H_RES * V_RES;
  localparam int                ADDR_W    = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_DRAW,
    S_WAIT_SWAP,
    S_CLEAR
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   scan_addr;
  logic [ADDR_W-1:0]   clear_addr;
  logic [COLOR_W-1:0]  rd_data;

  logic                in_range;
  logic [ADDR_W-1:0]   pix_addr;
  logic                scan_issue;
  logic                scan_last;
  logic                pix_take;

  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [COLOR_W-1:0]  wr_data;

  // Both banks in one array; the first index selects the bank.
  logic [COLOR_W-1:0]  mem [2][DEPTH];

  // One extra bit on the compare so H_RES == 2**X_W still works.
  assign in_range = ({1'b0, rast_width}  < (X_W + 1)'(H_RES)) &&
                    ({1'b0, rast_height} < (Y_W + 1)'(V_RES));
  assign pix_addr = ADDR_W'(rast_height) * ADDR_W'(H_RES) + ADDR_W'(rast_width);

  // The full flag is looked at only when a read is issued; the data lands one
  // cycle later, so the FIFO has to keep a slot of slack when it reports full.
  assign scan_issue = !dvi_fifo_full;
  assign scan_last  = (scan_addr == LAST_ADDR);
  assign pix_take   = (state == S_DRAW) && rast_pixel_rdy;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = pix_addr;
    wr_data = rast_color_input;
    if (state == S_CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = clear_addr;
      wr_data = CLEAR_COLOR;
    end else if (pix_take && in_range) begin
      wr_en = 1'b1;
    end
  end

  // Writes always target the back bank and reads the front bank, so the two
  // ports never touch the same bank and need no collision handling.
  // NOTE: the storage array has no reset; contents are undefined after reset
  // and adding one would prevent mapping onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[~front_sel][wr_addr] <= wr_data;
    end
    rd_data <= mem[front_sel][scan_addr];
  end

  // The read data register is free-running; it is only exposed when valid so
  // the output reads 0 whenever nothing is being pushed.
  assign dvi_color_out = dvi_fifo_write_enable ? rd_data : '0;
  assign rast_busy     = (state != S_DRAW);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values and ordering inside the block does not matter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                 <= S_DRAW;
      front_sel             <= 1'b0;
      scan_addr             <= '0;
      clear_addr            <= '0;
      read_rast_pixel_rdy   <= 1'b0;
      oob_err               <= 1'b0;
      dvi_fifo_write_enable <= 1'b0;
      frame_start           <= 1'b0;
    end else begin
      // Out-of-range pixels are still acknowledged so the rasterizer never stalls.
      read_rast_pixel_rdy <= pix_take;
      if (pix_take && !in_range) begin
        oob_err <= 1'b1;
      end

      dvi_fifo_write_enable <= scan_issue;
      frame_start           <= scan_issue && (scan_addr == '0);
      if (scan_issue) begin
        scan_addr <= scan_last ? '0 : scan_addr + ADDR_W'(1);
      end

      case (state)
        S_DRAW: begin
          if (rast_done && next_frame_switch) begin
            state <= S_WAIT_SWAP;
          end
        end
        S_WAIT_SWAP: begin
          // Swap on the issue of the last address so the read of address 0
          // that follows already comes from the new front bank.
          if (scan_issue && scan_last) begin
            front_sel  <= ~front_sel;
            clear_addr <= '0;
            state      <= CLEAR_ON_SWAP ? S_CLEAR : S_DRAW;
          end
        end
        S_CLEAR: begin
          if (clear_addr == LAST_ADDR) begin
            state <= S_DRAW;
          end else begin
            clear_addr <= clear_addr + ADDR_W'(1);
          end
        end
        default: state <= S_DRAW;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_buffer_dbuf.sv
// -----------------------------------------------------------------------------
// tb_frame_buffer_dbuf
//
// Two instances share one stimulus stream: dut_keep (no clear on swap) and
// dut_clr (clear to 5 on swap). A reference model tracks state, banks and scan
// address for each; expected scanout pixels are queued when a read is issued
// and popped when the DUT pushes. Table vectors cover pixel acceptance and
// range checking; hand-written sequences cover swap timing, stalls and reset.
// -----------------------------------------------------------------------------
module tb_frame_buffer_dbuf;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int N  = H * V;
  localparam int XW = 4;
  localparam int YW = 3;
  localparam int CW = 3;
  localparam logic [CW-1:0] CLR_COL = 3'd5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rdy = 1'b0;
  logic [XW-1:0] px  = '0;
  logic [YW-1:0] py  = '0;
  logic [CW-1:0] pc  = '0;
  logic          done = 1'b0;
  logic          sw   = 1'b0;
  logic          full = 1'b0;

  logic [1:0]    ack, busy, oob, we, fs, fsel;
  logic [CW-1:0] color0, color1;

  always #5 clk = ~clk;

  frame_buffer_dbuf #(
    .H_RES(H), .V_RES(V), .X_W(XW), .Y_W(YW), .COLOR_W(CW),
    .CLEAR_ON_SWAP(1'b0), .CLEAR_COLOR(CLR_COL)
  ) dut_keep (
    .clk(clk), .rst(rst),
    .rast_pixel_rdy(rdy), .rast_width(px), .rast_height(py),
    .rast_color_input(pc), .rast_done(done), .next_frame_switch(sw),
    .read_rast_pixel_rdy(ack[0]), .rast_busy(busy[0]), .oob_err(oob[0]),
    .dvi_fifo_full(full), .dvi_color_out(color0),
    .dvi_fifo_write_enable(we[0]), .frame_start(fs[0]), .front_sel(fsel[0])
  );

  frame_buffer_dbuf #(
    .H_RES(H), .V_RES(V), .X_W(XW), .Y_W(YW), .COLOR_W(CW),
    .CLEAR_ON_SWAP(1'b1), .CLEAR_COLOR(CLR_COL)
  ) dut_clr (
    .clk(clk), .rst(rst),
    .rast_pixel_rdy(rdy), .rast_width(px), .rast_height(py),
    .rast_color_input(pc), .rast_done(done), .next_frame_switch(sw),
    .read_rast_pixel_rdy(ack[1]), .rast_busy(busy[1]), .oob_err(oob[1]),
    .dvi_fifo_full(full), .dvi_color_out(color1),
    .dvi_fifo_write_enable(we[1]), .frame_start(fs[1]), .front_sel(fsel[1])
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int d,
                       input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s dut%0d: got %0d, expected %0d (t=%0t)", name, d, act, exp, $time);
    end
  endtask

  function automatic logic [CW-1:0] dut_color(input int d);
    return (d == 0) ? color0 : color1;
  endfunction

  // ---------------------------------------------------------------- model
  typedef enum int {M_DRAW, M_WAIT, M_CLEAR} mstate_t;
  typedef struct {
    bit            known;
    logic [CW-1:0] color;
    bit            first;
  } exp_pix_t;

  mstate_t       m_state [2];
  bit            m_front [2];
  int            m_scan  [2];
  int            m_clr   [2];
  bit            m_oob   [2];
  logic [CW-1:0] m_mem   [2][2][N];
  bit            m_known [2][2][N];
  exp_pix_t      sb      [2][$];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_state[d] = M_DRAW;
      m_front[d] = 1'b0;
      m_scan[d]  = 0;
      m_clr[d]   = 0;
      m_oob[d]   = 1'b0;
      sb[d].delete();
    end
  endtask

  // One clock: predict from pre-edge inputs, clock, then compare #1 after.
  task automatic tick();
    bit exp_ack [2];
    bit exp_we  [2];
    for (int d = 0; d < 2; d++) begin
      int back;
      int a;
      exp_pix_t e;
      back       = m_front[d] ? 0 : 1;
      exp_ack[d] = (m_state[d] == M_DRAW) && rdy;
      exp_we[d]  = !full;
      if (!full) begin
        e.known = m_known[d][m_front[d]][m_scan[d]];
        e.color = m_mem[d][m_front[d]][m_scan[d]];
        e.first = (m_scan[d] == 0);
        sb[d].push_back(e);
      end
      if (m_state[d] == M_DRAW && rdy) begin
        if (int'(px) < H && int'(py) < V) begin
          a = int'(py) * H + int'(px);
          m_mem[d][back][a]   = pc;
          m_known[d][back][a] = 1'b1;
        end else begin
          m_oob[d] = 1'b1;
        end
      end
      case (m_state[d])
        M_DRAW: if (done && sw) m_state[d] = M_WAIT;
        M_WAIT: if (!full && m_scan[d] == N - 1) begin
          m_front[d] = !m_front[d];
          m_clr[d]   = 0;
          m_state[d] = (d == 1) ? M_CLEAR : M_DRAW;
        end
        M_CLEAR: begin
          m_mem[d][back][m_clr[d]]   = CLR_COL;
          m_known[d][back][m_clr[d]] = 1'b1;
          if (m_clr[d] == N - 1) m_state[d] = M_DRAW;
          else m_clr[d]++;
        end
        default: m_state[d] = M_DRAW;
      endcase
      if (!full) m_scan[d] = (m_scan[d] == N - 1) ? 0 : m_scan[d] + 1;
    end

    @(posedge clk);
    #1;

    for (int d = 0; d < 2; d++) begin
      exp_pix_t e;
      check("ack", d, 32'(ack[d]), 32'(exp_ack[d]));
      check("busy", d, 32'(busy[d]), 32'(m_state[d] != M_DRAW));
      check("oob_err", d, 32'(oob[d]), 32'(m_oob[d]));
      check("front_sel", d, 32'(fsel[d]), 32'(m_front[d]));
      check("push_valid", d, 32'(we[d]), 32'(exp_we[d]));
      if (we[d]) begin
        if (sb[d].size() == 0) begin
          check("scoreboard_empty", d, 32'd1, 32'd0);
        end else begin
          e = sb[d].pop_front();
          check("frame_start_sb", d, 32'(fs[d]), 32'(e.first));
          if (e.known) check("pixel_sb", d, 32'(dut_color(d)), 32'(e.color));
        end
      end
    end
  endtask

  task automatic check_idle(input string tag);
    for (int d = 0; d < 2; d++) begin
      check({tag, "_ack"},   d, 32'(ack[d]),  32'd0);
      check({tag, "_busy"},  d, 32'(busy[d]), 32'd0);
      check({tag, "_oob"},   d, 32'(oob[d]),  32'd0);
      check({tag, "_we"},    d, 32'(we[d]),   32'd0);
      check({tag, "_fs"},    d, 32'(fs[d]),   32'd0);
      check({tag, "_fsel"},  d, 32'(fsel[d]), 32'd0);
      check({tag, "_color"}, d, 32'(dut_color(d)), 32'd0);
    end
  endtask

  task automatic request_swap();
    done = 1'b1;
    sw   = 1'b1;
    tick();
    done = 1'b0;
    sw   = 1'b0;
  endtask

  // Ticks until dut_keep's front_sel changes; returns the tick count.
  task automatic wait_toggle(output int n);
    logic start;
    bit   hit;
    start = fsel[0];
    hit   = 1'b0;
    n     = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      tick();
      n++;
      if (fsel[0] != start) hit = 1'b1;
    end
    if (!hit) check("swap_timeout", 0, 32'd0, 32'd1);
  endtask

  // Called on the sample where the swap became visible. The next N pushes
  // must be addresses 0..N-1 of the new front. mode: 0 = addr%8,
  // 1 = (addr+3)%8, 2 = clear color.
  task automatic check_frame(input int mode0, input int mode1, output int busy_cnt);
    busy_cnt = busy[1] ? 1 : 0;
    full     = 1'b0;
    for (int i = 0; i < N; i++) begin
      tick();
      if (busy[1]) busy_cnt++;
      for (int d = 0; d < 2; d++) begin
        int mode;
        int exp;
        mode = (d == 0) ? mode0 : mode1;
        exp  = (mode == 0) ? i % 8 : (mode == 1) ? (i + 3) % 8 : int'(CLR_COL);
        check("frame_push", d, 32'(we[d]), 32'd1);
        check("frame_color", d, 32'(dut_color(d)), 32'(exp));
        check("frame_first", d, 32'(fs[d]), 32'(i == 0));
      end
    end
  endtask

  task automatic fill_back(input int offset);
    for (int a = 0; a < N; a++) begin
      rdy = 1'b1;
      px  = XW'(a % H);
      py  = YW'(a / H);
      pc  = CW'((a + offset) % 8);
      tick();
    end
    rdy = 1'b0;
  endtask

  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    #1;
    check_idle(tag);
    @(posedge clk);
    @(posedge clk);
    #1;
    check_idle({tag, "_held"});
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    bit            rdy;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] c;
    bit            exp_ack;
    bit            exp_oob;
  } pix_vec_t;

  pix_vec_t vecs [6];

  initial begin
    int n;
    int bc;

    // In-range entries rewrite the pattern value; out-of-range ones alias to
    // addresses 8 and 0 if the range check were missing.
    vecs[0] = '{1'b1, 4'd0, 3'd0, 3'd0, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 4'd7, 3'd3, 3'd7, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 4'd8, 3'd0, 3'd7, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 4'd0, 3'd4, 3'd2, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 4'd1, 3'd1, 3'd6, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 4'd5, 3'd1, 3'd5, 1'b1, 1'b1};

    for (int d = 0; d < 2; d++)
      for (int b = 0; b < 2; b++)
        for (int a = 0; a < N; a++) begin
          m_mem[d][b][a]   = '0;
          m_known[d][b][a] = 1'b0;
        end
    model_reset();

    // Reset state
    #1;
    check_idle("reset");
    #20;
    @(negedge clk);
    rst = 1'b0;

    // Fill back bank with addr%8, then out-of-range and edge pixels
    fill_back(0);
    for (int i = 0; i < 6; i++) begin
      rdy = vecs[i].rdy;
      px  = vecs[i].x;
      py  = vecs[i].y;
      pc  = vecs[i].c;
      tick();
      for (int d = 0; d < 2; d++) begin
        check("vec_ack", d, 32'(ack[d]), 32'(vecs[i].exp_ack));
        check("vec_oob", d, 32'(oob[d]), 32'(vecs[i].exp_oob));
      end
    end
    rdy = 1'b0;

    // First swap: new front shows 0..7 repeating; clear runs exactly N cycles
    request_swap();
    wait_toggle(n);
    check("swap1_front_sel", 0, 32'(fsel[0]), 32'd1);
    check("swap1_busy_keep", 0, 32'(busy[0]), 32'd0);
    check_frame(0, 0, bc);
    check("clear_busy_cycles", 1, 32'(bc), 32'(N));
    check("oob_sticky", 0, 32'(oob[0]), 32'd1);

    // Swap requested while address 10 is issued: 10..31 come from old bank
    fill_back(3);
    for (int i = 0; i < 2 * N && m_scan[0] != 10; i++) tick();
    check("reach_addr10", 0, 32'(m_scan[0]), 32'd10);
    request_swap();
    wait_toggle(n);
    check("swap_latency", 0, 32'(n + 1), 32'd22);
    check("old_bank_last", 0, 32'(color0), 32'd7);
    check_frame(1, 1, bc);

    // Swap with a 5-cycle FIFO stall: keep retains old back, clr reads all 5
    request_swap();
    for (int i = 0; i < 3; i++) tick();
    full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      for (int d = 0; d < 2; d++) check("stall_no_push", d, 32'(we[d]), 32'd0);
    end
    full = 1'b0;
    wait_toggle(n);
    check_frame(0, 2, bc);

    // Reset in the middle of a clear and of a scan
    request_swap();
    wait_toggle(n);
    for (int i = 0; i < 5; i++) tick();
    check("pre_reset_clearing", 1, 32'(busy[1]), 32'd1);
    pulse_reset("mid_reset");
    rdy = 1'b1;
    px  = 4'd2;
    py  = 3'd2;
    pc  = 3'd4;
    tick();
    rdy = 1'b0;
    for (int d = 0; d < 2; d++) check("post_reset_ack", d, 32'(ack[d]), 32'd1);
    for (int i = 0; i < 40; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
